// File: rtl/counter.sv
// counter: free-running 16-bit LED counter with optional clock-enable prescaler
module counter #(
  parameter int DIVIDER = 1,
  parameter int WIDTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] left_leds,
  output logic [7:0] right_leds
);
  localparam int PW = $clog2(DIVIDER) + 1;
  logic [WIDTH-1:0] count;
  logic [PW-1:0]    pre;
  logic             tick;
  // With DIVIDER = 1 the prescaler is held at zero and every edge ticks
  always_comb tick = (DIVIDER == 1) ? 1'b1 : (pre == PW'(DIVIDER - 1));
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      pre   <= '0;
    end else begin
      count <= tick ? count + WIDTH'(1) : count;
      pre   <= tick ? '0 : pre + PW'(1);
    end
  end
  assign left_leds  = count[WIDTH-1:8];
  assign right_leds = count[7:0];
endmodule

// File: tb/tb_counter.sv
// tb_counter: vector table, corner sequences and random resets against a cycle-count model
module tb_counter;
  logic clk = 1'b0;
  logic rst1, rst4;
  logic [7:0] l1, r1, l4, r4;
  int checks = 0;
  int errors = 0;
  longint n1 = 0;
  longint n4 = 0;
  typedef struct {
    bit          rst;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[32];

  counter #(.DIVIDER(1)) dut1 (.clock(clk), .reset(rst1), .left_leds(l1), .right_leds(r1));
  counter #(.DIVIDER(4)) dut4 (.clock(clk), .reset(rst4), .left_leds(l4), .right_leds(r4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: count equals completed DIVIDER-length periods since the last reset edge
  task automatic step(input bit a, input bit b);
    @(negedge clk);
    rst1 = a;
    rst4 = b;
    @(posedge clk);
    #1;
    n1 = a ? 0 : n1 + 1;
    n4 = b ? 0 : n4 + 1;
    chk("model_div1", {l1, r1}, 16'(n1 % 65536));
    chk("model_div4", {l4, r4}, 16'((n4 / 4) % 65536));
  endtask

  initial begin
    rst1 = 1'b1;
    rst4 = 1'b1;
    tbl[0] = '{1'b1, 16'h0000};
    for (int i = 1; i <= 20; i++) tbl[i] = '{1'b0, 16'(i)};
    for (int i = 21; i <= 30; i++) tbl[i] = '{1'b1, 16'h0000};
    tbl[31] = '{1'b0, 16'h0001};
    for (int i = 0; i < 32; i++) begin
      step(tbl[i].rst, 1'b1);
      chk($sformatf("table_%0d", i), {l1, r1}, tbl[i].exp);
    end
    step(1'b1, 1'b1);
    for (int i = 0; i < 255; i++) step(1'b0, 1'b0);
    chk("byte_ff", {l1, r1}, 16'h00FF);
    step(1'b0, 1'b0);
    chk("carry_0100", {l1, r1}, 16'h0100);
    chk("div4_after_256", {l4, r4}, 16'h0040);
    step(1'b1, 1'b1);
    for (int i = 0; i < 65536; i++) step(1'b0, 1'b0);
    chk("wrap_0000", {l1, r1}, 16'h0000);
    step(1'b0, 1'b0);
    chk("wrap_then_1", {l1, r1}, 16'h0001);
    step(1'b1, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      if (i == 3) chk("div4_edge3", {l4, r4}, 16'h0000);
      if (i == 4) chk("div4_edge4", {l4, r4}, 16'h0001);
      if (i == 7) chk("div4_edge7", {l4, r4}, 16'h0001);
      if (i == 8) chk("div4_edge8", {l4, r4}, 16'h0002);
      if (i == 12) chk("div4_edge12", {l4, r4}, 16'h0003);
    end
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("div4_reset_on_tick", {l4, r4}, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0);
      if (i == 3) chk("div4_restart_edge3", {l4, r4}, 16'h0000);
      if (i == 4) chk("div4_restart_edge4", {l4, r4}, 16'h0001);
    end
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
